ps2_rx_fifo: RTL and testbench

PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_sync_fifo.sv | 64 ++++++
 rtl/ps2_rx_fifo.sv | 128 ++++++++++++
 tb/tb_ps2_rx_fifo.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_pkg
// Brief    : Shared PS/2 receive constants, frame layout and FIFO sizing helper
// Revision : 1.0
// ============================================================================
package ps2_pkg;

  localparam int PS2_FRAME_BITS          = 11;
  localparam int PS2_TIMEOUT_CYC_DEFAULT = 4096;
  localparam int PS2_CNT_W               = $clog2(PS2_FRAME_BITS);

  // Shift-register image after start, data and parity have been taken LSB-first
  typedef struct packed {
    logic       parity;
    logic [7:0] data;
    logic       start;
  } ps2_frame_t;

  function automatic int ps2_ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ps2_sync_fifo
// Brief    : Single-clock scancode FIFO with wrap-bit pointers and overflow pulse
// Revision : 1.0
// ============================================================================
module ps2_sync_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic             overflow
);

  localparam int c_PW = ps2_ptr_width(DEPTH);
  localparam int c_AW = c_PW - 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_PW-1:0]  r_wr_ptr;
  logic [c_PW-1:0]  r_rd_ptr;
  logic             r_overflow;
  logic             w_rd;
  logic             w_wr;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[c_PW-1] != r_rd_ptr[c_PW-1]) &&
                 (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

  // A pop frees the slot being written, so push-while-full is legal with a pop
  assign w_rd = rd_en && !empty;
  assign w_wr = wr_en && (!full || w_rd);

  assign rd_data  = r_mem[r_rd_ptr[c_AW-1:0]];
  assign overflow = r_overflow;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr[c_AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= wr_en && full && !w_rd;
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ps2_rx_fifo
// Brief    : PS/2 frame receiver with timeout and scancode FIFO.
//            Define PS2_RX_PARITY_CHECK_EN to enforce odd parity.
// Revision : 1.0
// ============================================================================
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = PS2_TIMEOUT_CYC_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       ready,
  input  logic       nextdata_n,
  output logic       overflow,
  output logic       frame_err
);

  localparam int                   c_IDLE_W   = $clog2(TIMEOUT_CYC + 1);
  localparam int                   c_SHIFT_W  = $bits(ps2_frame_t);
  localparam logic [PS2_CNT_W-1:0] c_STOP_CNT = PS2_CNT_W'(PS2_FRAME_BITS - 1);
  localparam logic [c_IDLE_W-1:0]  c_IDLE_MAX = c_IDLE_W'(TIMEOUT_CYC - 1);

  logic [2:0]           r_clk_sync;
  logic [1:0]           r_data_sync;
  logic [c_SHIFT_W-1:0] r_shift;
  logic [PS2_CNT_W-1:0] r_bit_cnt;
  logic [c_IDLE_W-1:0]  r_idle;
  logic                 r_frame_err;

  logic                 w_fall;
  logic                 w_bit;
  logic                 w_stop_edge;
  logic                 w_parity_ok;
  logic                 w_frame_ok;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_timeout;
  logic                 w_empty;
  logic                 w_full;
  logic [7:0]           w_rd_data;
  ps2_frame_t           w_frame;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_sync  <= 3'b111;
      r_data_sync <= 2'b11;
    end else begin
      r_clk_sync  <= {r_clk_sync[1:0], ps2_clk};
      r_data_sync <= {r_data_sync[0], ps2_data};
    end
  end

  assign w_fall  = r_clk_sync[2] & ~r_clk_sync[1];
  assign w_bit   = r_data_sync[1];
  assign w_frame = ps2_frame_t'(r_shift);

  assign w_stop_edge = w_fall && (r_bit_cnt == c_STOP_CNT);

`ifdef PS2_RX_PARITY_CHECK_EN
  assign w_parity_ok = ^{w_frame.data, w_frame.parity};
`else
  logic w_unused_parity;
  assign w_unused_parity = w_frame.parity;
  assign w_parity_ok     = 1'b1;
`endif

  // The stop bit is the live sample, never stored in the shift register
  assign w_frame_ok = !w_frame.start && w_bit && w_parity_ok;
  assign w_push     = w_stop_edge && w_frame_ok;
  assign w_timeout  = (r_bit_cnt != '0) && !w_fall && (r_idle == c_IDLE_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_idle      <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= (w_stop_edge && !w_frame_ok) || w_timeout;
      if (w_fall) begin
        r_idle <= '0;
        if (w_stop_edge) begin
          r_bit_cnt <= '0;
        end else begin
          r_shift   <= {w_bit, r_shift[c_SHIFT_W-1:1]};
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end else if (r_bit_cnt != '0) begin
        if (w_timeout) begin
          r_bit_cnt <= '0;
          r_idle    <= '0;
        end else begin
          r_idle <= r_idle + 1'b1;
        end
      end
    end
  end

  assign w_pop = !w_empty && !nextdata_n;

  ps2_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (w_push),
    .wr_data  (w_frame.data),
    .rd_en    (w_pop),
    .rd_data  (w_rd_data),
    .empty    (w_empty),
    .full     (w_full),
    .overflow (overflow)
  );

  assign ready     = !w_empty;
  assign data      = rst ? 8'h00 : w_rd_data;
  assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_rx_fifo
// Brief    : Directed self-checking bench for ps2_rx_fifo
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_ps2_rx_fifo;

  localparam int HALF = 10;

  logic       clk        = 1'b0;
  logic       rst        = 1'b1;
  logic       ps2_clk    = 1'b1;
  logic       ps2_data   = 1'b1;
  logic       nextdata_n = 1'b1;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  int tests    = 0;
  int fails    = 0;
  int ovf_cnt  = 0;
  int ferr_cnt = 0;

  ps2_rx_fifo dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .data       (data),
    .ready      (ready),
    .nextdata_n (nextdata_n),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (overflow)  ovf_cnt  <= ovf_cnt + 1;
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
  end

  task automatic send_bit(input logic b);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_head(input logic [7:0] v, input logic flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
    send_bit((~^v) ^ flip);
  endtask

  task automatic send_frame(input logic [7:0] v, input logic flip);
    send_head(v, flip);
    send_bit(1'b1);
    repeat (4) @(negedge clk);
  endtask

  task automatic do_pop();
    nextdata_n = 1'b0;
    @(negedge clk);
    nextdata_n = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b want 0", ready); end
    tests++; if (data !== 8'h00) begin fails++; $display("FAIL reset_data got %h want 00", data); end
    tests++; if (overflow !== 1'b0 || frame_err !== 1'b0) begin
      fails++; $display("FAIL reset_pulses got ovf=%b ferr=%b want 0/0", overflow, frame_err);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single();
    int o0 = ovf_cnt;
    int f0 = ferr_cnt;
    send_head(8'h1C, 1'b0);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL single_early_ready got %b want 0", ready); end
    @(negedge clk);
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL single_ready got %b want 1", ready); end
    tests++; if (data !== 8'h1C) begin fails++; $display("FAIL single_data got %h want 1c", data); end
    repeat (HALF - 3) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
    tests++; if (ovf_cnt !== o0 || ferr_cnt !== f0) begin
      fails++; $display("FAIL single_pulses got ovf=%0d ferr=%0d want %0d/%0d", ovf_cnt, ferr_cnt, o0, f0);
    end
    do_pop();
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL single_pop_ready got %b want 0", ready); end
  endtask

  task automatic test_overflow();
    int o0 = ovf_cnt;
    for (int v = 1; v <= 8; v++) send_frame(8'(v), 1'b0);
    tests++; if (ovf_cnt !== o0) begin fails++; $display("FAIL ovf_early got %0d want %0d", ovf_cnt, o0); end
    send_frame(8'h09, 1'b0);
    tests++; if (ovf_cnt !== o0 + 1) begin fails++; $display("FAIL ovf_count got %0d want %0d", ovf_cnt, o0 + 1); end
    for (int v = 1; v <= 8; v++) begin
      tests++; if (ready !== 1'b1 || data !== 8'(v)) begin
        fails++; $display("FAIL ovf_pop got ready=%b data=%h want 1/%h", ready, data, 8'(v));
      end
      do_pop();
    end
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL ovf_empty got %b want 0", ready); end
  endtask

  task automatic test_simul();
    int o0;
    for (int v = 1; v <= 8; v++) send_frame(8'(v), 1'b0);
    tests++; if (dut.w_full !== 1'b1) begin fails++; $display("FAIL simul_prefull got %b want 1", dut.w_full); end
    o0 = ovf_cnt;
    send_head(8'h09, 1'b0);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (2) @(negedge clk);
    nextdata_n = 1'b0;
    @(negedge clk);
    nextdata_n = 1'b1;
    repeat (HALF - 3) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
    tests++; if (ovf_cnt !== o0) begin fails++; $display("FAIL simul_ovf got %0d want %0d", ovf_cnt, o0); end
    tests++; if (dut.w_full !== 1'b1) begin fails++; $display("FAIL simul_full got %b want 1", dut.w_full); end
    for (int v = 2; v <= 9; v++) begin
      tests++; if (ready !== 1'b1 || data !== 8'(v)) begin
        fails++; $display("FAIL simul_pop got ready=%b data=%h want 1/%h", ready, data, 8'(v));
      end
      do_pop();
    end
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL simul_empty got %b want 0", ready); end
  endtask

  task automatic test_parity();
    int f0 = ferr_cnt;
    send_frame(8'h1C, 1'b1);
`ifdef PS2_RX_PARITY_CHECK_EN
    tests++; if (ferr_cnt !== f0 + 1) begin fails++; $display("FAIL parity_err got %0d want %0d", ferr_cnt, f0 + 1); end
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL parity_fifo got ready=%b want 0", ready); end
`else
    tests++; if (ferr_cnt !== f0) begin fails++; $display("FAIL parity_err got %0d want %0d", ferr_cnt, f0); end
    tests++; if (ready !== 1'b1 || data !== 8'h1C) begin
      fails++; $display("FAIL parity_accept got ready=%b data=%h want 1/1c", ready, data);
    end
    do_pop();
`endif
  endtask

  task automatic test_timeout();
    int f0 = ferr_cnt;
    int cyc = 0;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    while (ferr_cnt == f0 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    tests++; if (ferr_cnt !== f0 + 1 || cyc < 4000 || cyc > 4200) begin
      fails++; $display("FAIL timeout_err got cnt=%0d after %0d cycles want %0d within 4000..4200", ferr_cnt, cyc, f0 + 1);
    end
    tests++; if (dut.r_bit_cnt !== 4'd0) begin fails++; $display("FAIL timeout_count got %0d want 0", dut.r_bit_cnt); end
    send_frame(8'hF0, 1'b0);
    tests++; if (ready !== 1'b1 || data !== 8'hF0) begin
      fails++; $display("FAIL timeout_next got ready=%b data=%h want 1/f0", ready, data);
    end
    tests++; if (ferr_cnt !== f0 + 1) begin fails++; $display("FAIL timeout_extra_err got %0d want %0d", ferr_cnt, f0 + 1); end
    do_pop();
  endtask

  task automatic test_reset_mid();
    logic [7:0] v = 8'h5A;
    send_frame(8'h33, 1'b0);
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL rstmid_pre got %b want 1", ready); end
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(v[i]);
    rst = 1'b1;
    @(negedge clk);
    tests++; if (ready !== 1'b0 || data !== 8'h00) begin
      fails++; $display("FAIL rstmid_out got ready=%b data=%h want 0/00", ready, data);
    end
    tests++; if (dut.r_bit_cnt !== 4'd0) begin fails++; $display("FAIL rstmid_count got %0d want 0", dut.r_bit_cnt); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    send_frame(8'h5A, 1'b0);
    tests++; if (ready !== 1'b1 || data !== 8'h5A) begin
      fails++; $display("FAIL rstmid_next got ready=%b data=%h want 1/5a", ready, data);
    end
    do_pop();
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL rstmid_empty got %b want 0", ready); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_simul();
    test_parity();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
